// File: rtl/exe_feedback_ctrl.sv
// EXE -> IF/ID feedback controller.
// Holds the NZCV status register, turns taken branches into a registered PC
// redirect with a programmable flush window, detects load-use hazards, and
// keeps saturating branch/stall counters for performance debug.
module exe_feedback_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             exe_b,
    input  logic             exe_s,
    input  logic [31:0]      exe_pc,
    input  logic [23:0]      exe_imm24,
    input  logic [3:0]       exe_nzcv,
    input  logic             exe_mem_r_en,
    input  logic             exe_wb_en,
    input  logic [3:0]       exe_dest,
    input  logic             id_valid,
    input  logic [3:0]       id_src1,
    input  logic [3:0]       id_src2,
    input  logic             id_two_src,
    output logic [3:0]       sr,
    output logic             branch_taken,
    output logic [31:0]      branch_addr,
    output logic             flush_if_id,
    output logic             flush_id_exe,
    output logic             hazard_stall,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // Window length minus one: fcnt==0 marks the last flush cycle.
    localparam logic [1:0] FCNT_INIT = 2'(FLUSH_CYCLES - 1);

    state_t             state;
    state_t             state_nxt;
    logic [1:0]         fcnt;
    logic [1:0]         fcnt_nxt;
    logic               redirect;
    logic               sr_load;
    logic               src_hit;
    logic signed [31:0] br_off;
    logic [31:0]        br_tgt;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Word offset sign-extended and scaled to bytes; the add wraps modulo 2^32.
    assign br_off = {{6{exe_imm24[23]}}, exe_imm24, 2'b00};
    assign br_tgt = exe_pc + $unsigned(br_off);

    // A load whose destination feeds either source read in ID must stall one cycle.
    assign src_hit      = (id_src1 == exe_dest) || (id_two_src && (id_src2 == exe_dest));
    assign hazard_stall = (state == RUN) && !rst && !exe_b && id_valid &&
                          exe_mem_r_en && exe_wb_en && src_hit;

    // Next-state logic: EXE-stage inputs only matter in RUN; FLUSH counts down blindly.
    always_comb begin
        state_nxt = state;
        fcnt_nxt  = fcnt;
        redirect  = 1'b0;
        sr_load   = 1'b0;
        case (state)
            RUN: begin
                if (exe_b) begin
                    state_nxt = FLUSH;
                    fcnt_nxt  = FCNT_INIT;
                    redirect  = 1'b1;
                end else if (exe_s) begin
                    sr_load = 1'b1;
                end
            end
            FLUSH: begin
                if (fcnt == 2'd0) begin
                    state_nxt = RUN;
                end else begin
                    fcnt_nxt = fcnt - 2'd1;
                end
            end
            default: begin
                state_nxt = RUN;
                fcnt_nxt  = 2'd0;
            end
        endcase
    end

    // State register; reset abandons any flush window in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            fcnt  <= 2'd0;
        end else begin
            state <= state_nxt;
            fcnt  <= fcnt_nxt;
        end
    end

    // Registered feedback outputs: status, redirect strobe/target and flushes.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr           <= 4'd0;
            branch_taken <= 1'b0;
            branch_addr  <= 32'd0;
            flush_if_id  <= 1'b0;
            flush_id_exe <= 1'b0;
        end else begin
            branch_taken <= redirect;
            flush_if_id  <= (state_nxt == FLUSH);
            flush_id_exe <= (state_nxt == FLUSH);
            if (redirect) begin
                branch_addr <= br_tgt;
            end
            if (sr_load) begin
                sr <= exe_nzcv;
            end
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            if (redirect) begin
                branch_cnt <= sat_inc(branch_cnt);
            end
            if (hazard_stall) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
        end
    end

endmodule

// File: tb/tb_exe_feedback_ctrl.sv
// Testbench for exe_feedback_ctrl. Two instances share the stimulus:
// dut_a uses FLUSH_CYCLES=1, CNT_W=16; dut_b uses FLUSH_CYCLES=3, CNT_W=2.
// Redirect targets go into a queue when a branch is driven and are popped
// when the strobe appears.
module tb_exe_feedback_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        exe_b, exe_s, exe_mem_r_en, exe_wb_en;
    logic [31:0] exe_pc;
    logic [23:0] exe_imm24;
    logic [3:0]  exe_nzcv, exe_dest;
    logic        id_valid, id_two_src;
    logic [3:0]  id_src1, id_src2;

    logic [3:0]  a_sr, b_sr;
    logic        a_bt, b_bt, a_fif, b_fif, a_fie, b_fie, a_hz, b_hz;
    logic [31:0] a_addr, b_addr;
    logic [15:0] a_bcnt, a_scnt;
    logic [1:0]  b_bcnt, b_scnt;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    exe_feedback_ctrl #(.FLUSH_CYCLES(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .exe_b(exe_b), .exe_s(exe_s), .exe_pc(exe_pc),
        .exe_imm24(exe_imm24), .exe_nzcv(exe_nzcv), .exe_mem_r_en(exe_mem_r_en),
        .exe_wb_en(exe_wb_en), .exe_dest(exe_dest), .id_valid(id_valid),
        .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
        .sr(a_sr), .branch_taken(a_bt), .branch_addr(a_addr), .flush_if_id(a_fif),
        .flush_id_exe(a_fie), .hazard_stall(a_hz), .branch_cnt(a_bcnt), .stall_cnt(a_scnt)
    );

    exe_feedback_ctrl #(.FLUSH_CYCLES(3), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .exe_b(exe_b), .exe_s(exe_s), .exe_pc(exe_pc),
        .exe_imm24(exe_imm24), .exe_nzcv(exe_nzcv), .exe_mem_r_en(exe_mem_r_en),
        .exe_wb_en(exe_wb_en), .exe_dest(exe_dest), .id_valid(id_valid),
        .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
        .sr(b_sr), .branch_taken(b_bt), .branch_addr(b_addr), .flush_if_id(b_fif),
        .flush_id_exe(b_fie), .hazard_stall(b_hz), .branch_cnt(b_bcnt), .stall_cnt(b_scnt)
    );

    function automatic logic [31:0] model_target(input logic [31:0] pc, input logic [23:0] imm);
        logic signed [31:0] off;
        off = signed'(32'(signed'(imm))) * 4;
        return pc + 32'(off);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        exe_b = 0; exe_s = 0; exe_pc = 0; exe_imm24 = 0; exe_nzcv = 0;
        exe_mem_r_en = 0; exe_wb_en = 0; exe_dest = 0;
        id_valid = 0; id_src1 = 0; id_src2 = 0; id_two_src = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1; exe_b = 1; exe_s = 1; exe_nzcv = 4'hF; exe_pc = 32'h40; exe_imm24 = 24'h1;
        tick();
        checks++;
        if ({a_sr, a_bt, a_addr, a_fif, a_fie, a_bcnt, a_scnt} !== '0) begin
            errors++;
            $display("FAIL reset_c1: sr=%h bt=%b addr=%h fl=%b%b bc=%0d sc=%0d, want all 0",
                     a_sr, a_bt, a_addr, a_fif, a_fie, a_bcnt, a_scnt);
        end
        exe_b = 0; exe_mem_r_en = 1; exe_wb_en = 1; exe_dest = 4'd2;
        id_valid = 1; id_src1 = 4'd2;
        #1;
        checks++;
        if (a_hz !== 1'b0) begin
            errors++; $display("FAIL reset_hazard: got %b want 0", a_hz);
        end
        tick();
        checks++;
        if ({a_sr, b_sr, a_bt, a_fif, a_fie, a_scnt} !== '0) begin
            errors++;
            $display("FAIL reset_c2: sr=%h/%h bt=%b fl=%b%b sc=%0d, want all 0",
                     a_sr, b_sr, a_bt, a_fif, a_fie, a_scnt);
        end
        rst = 0;
        clear_inputs();
    endtask

    task automatic test_forward_branch();
        logic [31:0] exp;
        do_reset();
        exe_b = 1; exe_pc = 32'h100; exe_imm24 = 24'h000004;
        exp_q.push_back(32'h110);
        tick();
        clear_inputs();
        checks++;
        if (a_bt !== 1'b1) begin
            errors++; $display("FAIL fwd_taken: got %b want 1", a_bt);
        end
        if (exp_q.size() == 0) begin
            checks++; errors++; $display("FAIL fwd_queue: got empty want 1 entry");
        end else begin
            exp = exp_q.pop_front();
            checks++;
            if (a_addr !== exp) begin
                errors++; $display("FAIL fwd_addr: got %h want %h", a_addr, exp);
            end
        end
        checks++;
        if ({a_fif, a_fie} !== 2'b11 || a_bcnt !== 16'd1) begin
            errors++; $display("FAIL fwd_flush_cnt: fl=%b%b bc=%0d want 11 1", a_fif, a_fie, a_bcnt);
        end
        tick();
        checks++;
        if ({a_fif, a_fie, a_bt} !== 3'b000 || a_addr !== 32'h110) begin
            errors++;
            $display("FAIL fwd_after: fl=%b%b bt=%b addr=%h want 000 110", a_fif, a_fie, a_bt, a_addr);
        end
    endtask

    task automatic test_backward_branch();
        logic [31:0] exp;
        do_reset();
        exe_b = 1; exe_pc = 32'h4; exe_imm24 = 24'hFFFFFE;
        exp_q.push_back(32'hFFFFFFFC);
        tick();
        // Wrong-path branch with S set in the first window cycle.
        exe_b = 1; exe_s = 1; exe_nzcv = 4'hF; exe_pc = 32'h800; exe_imm24 = 24'h10;
        checks++;
        if (b_bt !== 1'b1 || {b_fif, b_fie} !== 2'b11) begin
            errors++; $display("FAIL bwd_first: bt=%b fl=%b%b want 1 11", b_bt, b_fif, b_fie);
        end
        if (exp_q.size() == 0) begin
            checks++; errors++; $display("FAIL bwd_queue: got empty want 1 entry");
        end else begin
            exp = exp_q.pop_front();
            checks++;
            if (b_addr !== exp) begin
                errors++; $display("FAIL bwd_addr: got %h want %h", b_addr, exp);
            end
        end
        tick();
        exe_b = 0;
        for (int i = 2; i <= 3; i++) begin
            checks++;
            if (b_bt !== 1'b0 || {b_fif, b_fie} !== 2'b11 || b_sr !== 4'h0 || b_addr !== 32'hFFFFFFFC) begin
                errors++;
                $display("FAIL bwd_cycle%0d: bt=%b fl=%b%b sr=%h addr=%h want 0 11 0 fffffffc",
                         i, b_bt, b_fif, b_fie, b_sr, b_addr);
            end
            tick();
        end
        clear_inputs();
        checks++;
        if ({b_fif, b_fie, b_bt} !== 3'b000 || b_sr !== 4'h0 || b_bcnt !== 2'd1) begin
            errors++;
            $display("FAIL bwd_end: fl=%b%b bt=%b sr=%h bc=%0d want 000 0 1", b_fif, b_fie, b_bt, b_sr, b_bcnt);
        end
    endtask

    task automatic test_status();
        logic [31:0] exp;
        do_reset();
        exe_s = 1; exe_nzcv = 4'b0110;
        tick();
        checks++;
        if (a_sr !== 4'b0110) begin
            errors++; $display("FAIL sr_load: got %b want 0110", a_sr);
        end
        exe_s = 1; exe_b = 1; exe_nzcv = 4'b1001; exe_pc = 32'h2000; exe_imm24 = 24'h000100;
        exp_q.push_back(model_target(32'h2000, 24'h000100));
        tick();
        clear_inputs();
        checks++;
        if (a_bt !== 1'b1 || a_sr !== 4'b0110) begin
            errors++; $display("FAIL sr_branch: bt=%b sr=%b want 1 0110", a_bt, a_sr);
        end
        if (exp_q.size() == 0) begin
            checks++; errors++; $display("FAIL sr_queue: got empty want 1 entry");
        end else begin
            exp = exp_q.pop_front();
            checks++;
            if (a_addr !== exp) begin
                errors++; $display("FAIL sr_addr: got %h want %h", a_addr, exp);
            end
        end
    endtask

    task automatic test_load_use();
        logic [31:0] exp;
        do_reset();
        exe_mem_r_en = 1; exe_wb_en = 1; exe_dest = 4'd3;
        id_valid = 1; id_src1 = 4'd5; id_src2 = 4'd3; id_two_src = 1;
        #1;
        checks++;
        if (a_hz !== 1'b1) begin
            errors++; $display("FAIL lu_src2: got %b want 1", a_hz);
        end
        tick();
        checks++;
        if (a_scnt !== 16'd1) begin
            errors++; $display("FAIL lu_cnt1: got %0d want 1", a_scnt);
        end
        id_two_src = 0;
        #1;
        checks++;
        if (a_hz !== 1'b0) begin
            errors++; $display("FAIL lu_one_src: got %b want 0", a_hz);
        end
        tick();
        id_src1 = 4'd3;
        #1;
        checks++;
        if (a_hz !== 1'b1) begin
            errors++; $display("FAIL lu_src1: got %b want 1", a_hz);
        end
        tick();
        checks++;
        if (a_scnt !== 16'd2) begin
            errors++; $display("FAIL lu_cnt2: got %0d want 2", a_scnt);
        end
        exe_b = 1; exe_pc = 32'h300; exe_imm24 = 24'h800000;
        exp_q.push_back(model_target(32'h300, 24'h800000));
        #1;
        checks++;
        if (a_hz !== 1'b0) begin
            errors++; $display("FAIL lu_branch_prio: got %b want 0", a_hz);
        end
        tick();
        exe_b = 0;
        #1;
        checks++;
        if (a_bt !== 1'b1 || a_hz !== 1'b0 || a_scnt !== 16'd2) begin
            errors++; $display("FAIL lu_redirect: bt=%b hz=%b sc=%0d want 1 0 2", a_bt, a_hz, a_scnt);
        end
        if (exp_q.size() == 0) begin
            checks++; errors++; $display("FAIL lu_queue: got empty want 1 entry");
        end else begin
            exp = exp_q.pop_front();
            checks++;
            if (a_addr !== exp) begin
                errors++; $display("FAIL lu_addr: got %h want %h", a_addr, exp);
            end
        end
        clear_inputs();
    endtask

    task automatic test_saturation();
        logic [31:0] exp;
        logic [1:0]  exp_cnt;
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            exe_b = 1; exe_pc = 32'h1000 * k; exe_imm24 = 24'(k * 3);
            exp_q.push_back(model_target(exe_pc, exe_imm24));
            tick();
            clear_inputs();
            exp_cnt = (k >= 3) ? 2'b11 : 2'(k);
            checks++;
            if (b_bt !== 1'b1 || b_bcnt !== exp_cnt) begin
                errors++; $display("FAIL sat_%0d: bt=%b bc=%0d want 1 %0d", k, b_bt, b_bcnt, exp_cnt);
            end
            if (exp_q.size() == 0) begin
                checks++; errors++; $display("FAIL sat_queue: got empty want 1 entry");
            end else begin
                exp = exp_q.pop_front();
                checks++;
                if (b_addr !== exp) begin
                    errors++; $display("FAIL sat_addr%0d: got %h want %h", k, b_addr, exp);
                end
            end
            for (int w = 0; w < 3; w++) tick();
        end
    endtask

    task automatic test_mid_flush_reset();
        logic [31:0] exp;
        do_reset();
        exe_b = 1; exe_pc = 32'h500; exe_imm24 = 24'h2;
        tick();
        tick();
        checks++;
        if ({b_fif, b_fie} !== 2'b11 || b_bt !== 1'b0) begin
            errors++; $display("FAIL mfr_second: fl=%b%b bt=%b want 11 0", b_fif, b_fie, b_bt);
        end
        rst = 1;
        tick();
        rst = 0;
        checks++;
        if ({b_fif, b_fie, b_bt} !== 3'b000 || b_addr !== 32'h0) begin
            errors++;
            $display("FAIL mfr_reset: fl=%b%b bt=%b addr=%h want 000 0", b_fif, b_fie, b_bt, b_addr);
        end
        exe_b = 1; exe_pc = 32'h600; exe_imm24 = 24'h5;
        exp_q.push_back(model_target(32'h600, 24'h5));
        tick();
        clear_inputs();
        checks++;
        if (b_bt !== 1'b1) begin
            errors++; $display("FAIL mfr_run: bt=%b want 1", b_bt);
        end
        if (exp_q.size() == 0) begin
            checks++; errors++; $display("FAIL mfr_queue: got empty want 1 entry");
        end else begin
            exp = exp_q.pop_front();
            checks++;
            if (b_addr !== exp) begin
                errors++; $display("FAIL mfr_addr: got %h want %h", b_addr, exp);
            end
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_forward_branch();
        test_backward_branch();
        test_status();
        test_load_use();
        test_saturation();
        test_mid_flush_reset();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL queue_drain: got %0d entries want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/exe_feedback_ctrl.md
Name: exe_feedback_ctrl

Overview:
- Closes the loop from the EXE stage back to IF/ID. It is the counterpart of the ID/EXE pipeline register, which carries control and data forward.
- Holds the architectural NZCV status register that feeds SR into the decode stage.
- Resolves taken branches into a registered PC redirect, and drives the flush inputs of the IF/ID and ID/EXE registers for a programmable window.
- Detects load-use hazards and raises a stall toward the front end.
- Keeps saturating branch and stall counters for performance debug.

Parameters:
- FLUSH_CYCLES, 1, number of cycles flush_if_id and flush_id_exe stay high after a redirect; legal range 1..3.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- exe_b  input  1  instruction in EXE is a branch (B latched by ID/EXE).
- exe_s  input  1  instruction in EXE updates status (S latched by ID/EXE).
- exe_pc  input  32  PC value carried by the EXE instruction (already PC+4).
- exe_imm24  input  24  Signed_imm_24 of the EXE instruction.
- exe_nzcv  input  4  ALU status result for the EXE instruction, order {N,Z,C,V}.
- exe_mem_r_en  input  1  EXE instruction is a load.
- exe_wb_en  input  1  EXE instruction writes a register.
- exe_dest  input  4  destination register of the EXE instruction.
- id_valid  input  1  ID holds a real instruction.
- id_src1  input  4  first source register in ID.
- id_src2  input  4  second source register in ID.
- id_two_src  input  1  id_src2 is actually read.
- sr  output  4  architectural NZCV status; feeds decode SR_IN.
- branch_taken  output  1  one-cycle registered redirect strobe.
- branch_addr  output  32  redirect target; valid while branch_taken=1.
- flush_if_id  output  1  flush for the IF/ID register.
- flush_id_exe  output  1  flush for the ID/EXE register.
- hazard_stall  output  1  freeze PC and IF/ID; insert a bubble into ID/EXE.
- branch_cnt  output  CNT_W  taken branches since reset, saturating.
- stall_cnt  output  CNT_W  stall cycles since reset, saturating.

Behaviour:
- FSM states: RUN, FLUSH. A down-counter fcnt (2 bits) is active in FLUSH.
- Reset (rst=1 at posedge): state=RUN, sr=0, branch_taken=0, branch_addr=0, flush_if_id=0, flush_id_exe=0, fcnt=0, branch_cnt=0, stall_cnt=0.
  - hazard_stall=0 while rst=1.
  - Reset overrides everything, including mid-flush: the FSM returns to RUN immediately and no redirect is emitted.
- RUN, exe_b=1 at cycle t:
  - Next cycle: state=FLUSH, branch_taken=1, branch_addr = exe_pc + ({{6{imm24[23]}},imm24} << 2), computed modulo 2^32.
  - flush_if_id=flush_id_exe=1, fcnt=FLUSH_CYCLES-1, branch_cnt+1 (saturates at all-ones).
- FLUSH:
  - branch_taken is high only in the first FLUSH cycle; branch_addr holds its value afterwards.
  - Flushes stay high while in FLUSH. If fcnt=0 the next state is RUN and the flushes drop; otherwise fcnt decrements.
  - exe_b, exe_s and the hazard inputs are ignored in FLUSH: they describe wrong-path instructions. No SR update, no nested redirect, hazard_stall=0.
- SR update: when state=RUN, exe_s=1 and exe_b=0, the next cycle has sr=exe_nzcv.
  - If exe_s=1 and exe_b=1 in the same cycle, the redirect is taken and SR is NOT updated (branches never set flags).
- hazard_stall is combinational. It equals:
  - state=RUN & !rst & !exe_b & id_valid & exe_mem_r_en & exe_wb_en & (id_src1==exe_dest | (id_two_src & id_src2==exe_dest)).
- Priority: a branch in EXE suppresses the stall in the same cycle, because the ID instruction is wrong-path.
- stall_cnt increments (saturating) on every posedge where hazard_stall=1. A one-cycle stall clears naturally, because the bubble reaches EXE next cycle.
- No outputs depend combinationally on exe_nzcv or exe_imm24. All of sr, branch_*, flush_* and counters are registered.

Test Plan:
- Reset sequence:
  - Stimulus: assert rst for 2 cycles with exe_b=1, exe_s=1, exe_nzcv=4'hF.
  - Response: all outputs 0, hazard_stall=0, sr stays 0.
- Forward branch:
  - Stimulus: exe_b=1, exe_pc=32'h100, imm24=24'h000004, FLUSH_CYCLES=1.
  - Response: next cycle branch_taken=1, branch_addr=32'h110, both flushes 1 for exactly 1 cycle, branch_cnt=1.
- Backward branch with wrap, FLUSH_CYCLES=3:
  - Stimulus: exe_pc=32'h4, imm24=24'hFFFFFE.
  - Response: branch_addr=32'hFFFFFFFC; flushes high 3 cycles; branch_taken high only in the first.
  - Also: exe_b=1 and exe_s=1 during the window cause no second redirect and sr is unchanged.
- Status update:
  - Stimulus: exe_s=1, exe_nzcv=4'b0110.
  - Response: next cycle sr=4'b0110.
  - Then exe_s=1, exe_b=1, exe_nzcv=4'b1001: branch is taken, sr stays 4'b0110.
- Load-use hazard:
  - Stimulus: exe_mem_r_en=1, exe_wb_en=1, exe_dest=3, id_valid=1, id_src2=3, id_two_src=1.
  - Response: hazard_stall=1 and stall_cnt increments.
  - With id_two_src=0: hazard_stall=0.
  - Adding exe_b=1: hazard_stall=0 and a redirect is issued.
- Saturation and mid-flush reset:
  - CNT_W=2: after 5 branches, branch_cnt=2'b11.
  - rst asserted in the second FLUSH cycle: the next cycle has flushes=0 and state=RUN.
